// File: rtl/rcu_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rcu_rst_seq_if
// Description : Control/status bundle between the reset sequencer and its
//               requesters (watchdog, software reset, cause readback).
// Revision    : 1.0 - initial release
// ============================================================================
interface rcu_rst_seq_if #(
    parameter int NUM_DOM = 4
);
    logic               wdt_rst_i;
    logic [NUM_DOM-1:0] sw_rst_req_i;
    logic [NUM_DOM-1:0] sw_rst_ack_o;
    logic [NUM_DOM-1:0] dom_clk_en_o;
    logic [NUM_DOM-1:0] dom_rst_n_o;
    logic               seq_done_o;
    logic               rst_cause_clr_i;
    logic [2:0]         rst_cause_o;

    modport master (
        output wdt_rst_i, sw_rst_req_i, rst_cause_clr_i,
        input  sw_rst_ack_o, dom_clk_en_o, dom_rst_n_o, seq_done_o, rst_cause_o
    );

    modport slave (
        input  wdt_rst_i, sw_rst_req_i, rst_cause_clr_i,
        output sw_rst_ack_o, dom_clk_en_o, dom_rst_n_o, seq_done_o, rst_cause_o
    );
endinterface
`default_nettype wire

// File: rtl/rcu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : rcu_rst_seq
// Description : Ordered per-domain clock-enable/reset release with watchdog
//               and per-domain software reset. Optional RCU_RST_CAUSE_EN
//               enables the sticky {sw,wdt,por} reset-cause register.
// Revision    : 1.0 - initial release
// ============================================================================
module rcu_rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = 16,
    parameter int CLK_LEAD = 4,
    parameter int GAP_CYC  = 8
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    rcu_rst_seq_if.slave bus
);
    localparam int MAX_AB  = (HOLD_CYC > CLK_LEAD) ? HOLD_CYC : CLK_LEAD;
    localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(CLK_LEAD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2,
        ST_DOM_RST = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [NUM_DOM-1:0] r_clk_en, w_clk_en;
    logic [NUM_DOM-1:0] r_rst_n, w_rst_n;
    logic [NUM_DOM-1:0] r_ack, w_ack;
    logic               r_done, w_done;
    logic               w_sw_entry;
    logic               w_req_any;
    logic [IDX_W-1:0]   w_req_idx;

    // Lowest pending request wins; the rest wait their turn in DONE.
    always_comb begin
        w_req_any = |bus.sw_rst_req_i;
        w_req_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (bus.sw_rst_req_i[i]) w_req_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_clk_en <= '0;
            r_rst_n  <= '0;
            r_ack    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_clk_en <= w_clk_en;
            r_rst_n  <= w_rst_n;
            r_ack    <= w_ack;
            r_done   <= w_done;
        end
    end

    // Phase within RELEASE/DOM_RST is read from the current domain's outputs.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_clk_en   = r_clk_en;
        w_rst_n    = r_rst_n;
        w_ack      = '0;
        w_done     = r_done;
        w_sw_entry = 1'b0;
        if (bus.wdt_rst_i) begin
            w_state  = ST_ASSERT;
            w_cnt    = '0;
            w_idx    = '0;
            w_clk_en = '0;
            w_rst_n  = '0;
            w_done   = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_clk_en[0] = 1'b1;
                        w_state     = ST_RELEASE;
                        w_cnt       = '0;
                        w_idx       = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!r_rst_n[r_idx]) begin
                        if (r_cnt == LEAD_LAST) begin
                            w_rst_n[r_idx] = 1'b1;
                            w_cnt          = '0;
                            if (r_idx == IDX_LAST) w_state = ST_DONE;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end else if (r_cnt == GAP_LAST) begin
                        w_clk_en[r_idx + 1'b1] = 1'b1;
                        w_idx                  = r_idx + 1'b1;
                        w_cnt                  = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_req_any) begin
                        w_state             = ST_DOM_RST;
                        w_idx               = w_req_idx;
                        w_cnt               = '0;
                        w_clk_en[w_req_idx] = 1'b0;
                        w_rst_n[w_req_idx]  = 1'b0;
                        w_done              = 1'b0;
                        w_sw_entry          = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
                ST_DOM_RST: begin
                    if (!r_clk_en[r_idx]) begin
                        if (r_cnt == HOLD_LAST) begin
                            w_clk_en[r_idx] = 1'b1;
                            w_cnt           = '0;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end else if (!r_rst_n[r_idx]) begin
                        if (r_cnt == LEAD_LAST) begin
                            w_rst_n[r_idx] = 1'b1;
                            w_ack[r_idx]   = 1'b1;
                            w_cnt          = '0;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end else begin
                        // Ack cycle: requests are not sampled until the next DONE cycle.
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end
                end
                default: w_state = ST_ASSERT;
            endcase
        end
    end

    assign bus.sw_rst_ack_o = r_ack;
    assign bus.dom_clk_en_o = r_clk_en;
    assign bus.dom_rst_n_o  = r_rst_n;
    assign bus.seq_done_o   = r_done;

`ifdef RCU_RST_CAUSE_EN
    logic [2:0] r_cause;
    logic [2:0] w_cause_set;

    assign w_cause_set = {w_sw_entry, bus.wdt_rst_i, 1'b0};

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    r_cause <= 3'b001;
        else if (bus.rst_cause_clr_i) r_cause <= w_cause_set;
        else                          r_cause <= r_cause | w_cause_set;
    end

    assign bus.rst_cause_o = r_cause;
`else
    logic unused_sigs;
    assign unused_sigs     = ^{bus.rst_cause_clr_i, w_sw_entry};
    assign bus.rst_cause_o = 3'b000;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rcu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcu_rst_seq
// Description : Self-checking bench for rcu_rst_seq using a timeline-based
//               reference model (event times derived from release arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcu_rst_seq;
    localparam int N       = 4;
    localparam int H       = 16;
    localparam int L       = 4;
    localparam int G       = 8;
    localparam int T_DONE  = H + (N - 1) * (L + G) + L + 1;
    localparam int ACK_OFF = H + L;
    localparam int M_SEQ   = 0;
    localparam int M_DONE  = 1;
    localparam int M_SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rcu_rst_seq_if #(.NUM_DOM(N)) bus ();

    rcu_rst_seq #(
        .NUM_DOM (N),
        .HOLD_CYC(H),
        .CLK_LEAD(L),
        .GAP_CYC (G)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;
    int mode   = M_SEQ;
    int s_edge = 0;
    int e_edge = 0;
    int k_dom  = 0;
    logic [2:0]   m_cause  = 3'b001;
    logic [N-1:0] prev_ack = '0;
    logic [N-1:0] exp_clk, exp_rstn, exp_ack;
    logic         exp_done;
    logic [2:0]   exp_cause;

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Advance the reference timeline by one clock edge using the inputs seen there.
    task automatic model_edge();
        logic smp;
        logic sw_in;
        smp   = 1'b0;
        sw_in = 1'b0;
        if (rst) begin
            mode    = M_SEQ;
            s_edge  = cyc;
            m_cause = 3'b001;
            return;
        end
        if (bus.wdt_rst_i) begin
            mode   = M_SEQ;
            s_edge = cyc;
        end else begin
            case (mode)
                M_SEQ:   smp = ((cyc - s_edge) >= T_DONE);
                M_SW:    smp = ((cyc - e_edge) >= ACK_OFF + 2);
                default: smp = 1'b1;
            endcase
        end
        if (smp) begin
            if (bus.sw_rst_req_i != '0) begin
                mode   = M_SW;
                k_dom  = lowest(bus.sw_rst_req_i);
                e_edge = cyc;
                sw_in  = 1'b1;
            end else begin
                mode = M_DONE;
            end
        end
        if (bus.rst_cause_clr_i) m_cause = 3'b000;
        m_cause = m_cause | {sw_in, bus.wdt_rst_i, 1'b0};
    endtask

    task automatic model_outputs();
        int d;
        exp_ack  = '0;
        exp_done = 1'b0;
        exp_clk  = '1;
        exp_rstn = '1;
        if (mode == M_SEQ) begin
            d = cyc - s_edge;
            for (int i = 0; i < N; i++) begin
                exp_clk[i]  = (d >= H + i * (L + G));
                exp_rstn[i] = (d >= H + i * (L + G) + L);
            end
        end else if (mode == M_SW) begin
            d = cyc - e_edge;
            exp_clk[k_dom]  = (d >= H);
            exp_rstn[k_dom] = (d >= ACK_OFF);
            exp_ack[k_dom]  = (d == ACK_OFF);
            exp_done        = (d >= ACK_OFF + 1);
        end else begin
            exp_done = 1'b1;
        end
`ifdef RCU_RST_CAUSE_EN
        exp_cause = m_cause;
`else
        exp_cause = 3'b000;
`endif
    endtask

    task automatic check(input string tag);
        n_vec++;
        assert (bus.dom_clk_en_o === exp_clk) else begin
            n_err++;
            $error("FAIL %s clk_en cyc=%0d got %b exp %b", tag, cyc, bus.dom_clk_en_o, exp_clk);
        end
        n_vec++;
        assert (bus.dom_rst_n_o === exp_rstn) else begin
            n_err++;
            $error("FAIL %s rst_n cyc=%0d got %b exp %b", tag, cyc, bus.dom_rst_n_o, exp_rstn);
        end
        n_vec++;
        assert (bus.sw_rst_ack_o === exp_ack) else begin
            n_err++;
            $error("FAIL %s ack cyc=%0d got %b exp %b", tag, cyc, bus.sw_rst_ack_o, exp_ack);
        end
        n_vec++;
        assert (bus.seq_done_o === exp_done) else begin
            n_err++;
            $error("FAIL %s seq_done cyc=%0d got %b exp %b", tag, cyc, bus.seq_done_o, exp_done);
        end
        n_vec++;
        assert (bus.rst_cause_o === exp_cause) else begin
            n_err++;
            $error("FAIL %s cause cyc=%0d got %b exp %b", tag, cyc, bus.rst_cause_o, exp_cause);
        end
    endtask

    // One clock: model the edge, check 1 time unit later, then let the requester react.
    task automatic step(input string tag);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        model_outputs();
        check(tag);
        bus.sw_rst_req_i    = bus.sw_rst_req_i & ~prev_ack;
        prev_ack            = exp_ack;
        bus.wdt_rst_i       = 1'b0;
        bus.rst_cause_clr_i = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic por_pulse(input int hold);
        rst = 1'b1;
        #1;
        mode     = M_SEQ;
        s_edge   = cyc;
        m_cause  = 3'b001;
        prev_ack = '0;
        model_outputs();
        check("por_async");
        run(hold, "por_hold");
        rst = 1'b0;
    endtask

    initial begin
        bus.wdt_rst_i       = 1'b0;
        bus.sw_rst_req_i    = '0;
        bus.rst_cause_clr_i = 1'b0;

        run(3, "reset");
        rst = 1'b0;
        run(62, "power_up");

        bus.sw_rst_req_i = 4'b0100;
        run(30, "sw_dom2");

        bus.sw_rst_req_i = 4'b1010;
        run(60, "sw_dom1_dom3");

        bus.sw_rst_req_i = 4'b0100;
        run(8, "sw_before_wdt");
        bus.wdt_rst_i = 1'b1;
        step("wdt_in_domrst");
        run(90, "wdt_replay");

        bus.rst_cause_clr_i = 1'b1;
        step("cause_clr");
        run(3, "cause_idle");
        bus.rst_cause_clr_i = 1'b1;
        bus.wdt_rst_i       = 1'b1;
        step("clr_with_wdt");
        run(29, "seq_before_por");
        por_pulse(2);
        run(70, "seq_after_por");

        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) bus.wdt_rst_i = 1'b1;
            if ($urandom_range(0, 49) == 0) bus.rst_cause_clr_i = 1'b1;
            if ($urandom_range(0, 24) == 0)
                bus.sw_rst_req_i = bus.sw_rst_req_i | N'($urandom);
            if ($urandom_range(0, 599) == 0) por_pulse(2);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
